sextium_dma_master: RTL and testbench
=====================================

Name: sextium_dma_master

Overview:
- Bus initiator for the Sextium memory bus handshake (addr_bus / mem_bus_in / mem_bus_out / mem_read / mem_write / mem_ack).
- Copies a block of 16-bit words from a source region to a destination region by issuing read/write requests and waiting for the responder's mem_ack.
- Sits beside the CPU as a second bus master, behind the bus arbiter, in front of the RAM controller.
- Includes a per-request ack timeout and a word-boundary abort.

Parameters:
TIMEOUT, 16, max cycles a request may stay asserted without mem_ack; legal range 2..255.

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle command strobe; ignored while busy
src_addr  input  16  first source word address, sampled on start
dst_addr  input  16  first destination word address, sampled on start
length  input  16  word count, sampled on start; 0 is legal
abort  input  1  stop request; acted on at the next word boundary
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse when a transfer ends (normal, abort or error)
error  output  1  set on timeout; held until the next accepted start or reset
words_done  output  16  count of words fully written in the current/last transfer
addr_bus  output  16  bus address
mem_bus_in  input  16  read data from the responder
mem_bus_out  output  16  write data to the responder
mem_read  output  1  read request
mem_write  output  1  write request
mem_ack  input  1  responder acknowledge, one-cycle pulse

Behaviour:
- Reset values:
  - busy=0, done=0, error=0, words_done=0.
  - mem_read=0, mem_write=0, addr_bus=0, mem_bus_out=0.
  - FSM state = IDLE; timeout counter = 0.
- FSM states: IDLE, RD, WR. All outputs are registered.
- IDLE:
  - start=1 with length!=0: latch src, dst and len; clear error and words_done; next state RD.
  - Effects from the next cycle: busy=1, mem_read=1, addr_bus=src.
  - start=1 with length==0: clear error; words_done=0; done=1 for the next cycle. No bus activity; busy stays 0.
- Handshake rules:
  - A request (mem_read or mem_write) stays high, with addr_bus and mem_bus_out stable, until mem_ack is sampled high.
  - At the edge where mem_ack=1, the request is dropped or switched in that same edge. The master never holds a request into the cycle after ack, so a responder that computes ack = req & ~ack never sees a second request.
  - mem_read and mem_write are never high together.
- RD, at the ack edge:
  - Capture mem_bus_in into mem_bus_out.
  - mem_read<=0, mem_write<=1, addr_bus<=dst. Next state WR.
- WR, at the ack edge:
  - mem_write<=0; words_done++; src++; dst++; remaining--. Address increments wrap mod 2^16.
  - If remaining becomes 0, or abort was seen (see Abort): go to IDLE, busy<=0, done<=1.
  - Otherwise: mem_read<=1, addr_bus<=src, next state RD.
- Throughput with a 1-cycle-ack responder: exactly 4 cycles per word, no idle gaps.
- Abort:
  - Abort is recorded in a sticky flag any cycle while busy.
  - The in-flight word always completes its write.
  - The transfer ends at that word's write ack; error stays 0.
  - abort while IDLE has no effect.
- Timeout:
  - The counter clears whenever a new request is issued.
  - It increments on each edge where a request is high and mem_ack=0.
  - If mem_ack is still 0 when the counter reaches TIMEOUT-1: drop the request, error<=1, done<=1, busy<=0, go to IDLE. The request is high for exactly TIMEOUT cycles.
  - words_done keeps the count of completed words.
- mem_ack outside a request (IDLE or a spurious pulse) is ignored.
- start while busy is ignored.
- Reset mid-transfer: requests drop on the next edge and all outputs return to their reset values.

Test Plan:
1. Normal copy, 1-cycle-ack RAM model preloaded with mem[0x0010..0x0012]=0xAAAA,0xBBBB,0xCCCC. Pulse start in cycle 0 with src=0x0010, dst=0x0100, length=3 -> mem[0x0100..0x0102] equals those values; busy is high cycles 1-12; done pulses in cycle 13; words_done=3; mem_read/mem_write are never both high and never high in the cycle after an ack.
2. Wrap-around: src=0xFFFF, dst=0x7FFF, length=2 -> reads hit 0xFFFF then 0x0000; writes hit 0x7FFF then 0x8000.
3. length=0 -> done is high in the cycle after start; busy, mem_read and mem_write stay 0.
4. Timeout with TIMEOUT=16: responder never acks -> mem_read is high for exactly 16 cycles and then drops; error=1 and done pulses together; a following valid start clears error.
5. Abort: length=10, abort pulsed during word 2's read -> word 2's write completes; done pulses at that point with words_done=3 and error=0.
6. Reset asserted while mem_write=1 -> on the next cycle all outputs are 0; a later start runs normally. Also check start while busy is ignored and an idle mem_ack pulse is ignored.

Source files
------------

// File: rtl/sextium_dma_master.sv
// Sextium bus DMA master: copies a block of 16-bit words from src to dst over the
// read/write/ack handshake, with a per-request ack timeout and a word-boundary abort.
module sextium_dma_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_done,
  output logic [15:0] addr_bus,
  input  logic [15:0] mem_bus_in,
  output logic [15:0] mem_bus_out,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_nx;
  logic [15:0] src_q, src_nx;
  logic [15:0] dst_q, dst_nx;
  logic [15:0] rem_q, rem_nx;
  logic [15:0] words_nx, addr_nx, wdata_nx;
  logic [7:0]  tmo_q, tmo_nx;
  logic        abort_q, abort_nx;
  logic        busy_nx, done_nx, error_nx, rd_nx, wr_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      abort_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      words_done  <= '0;
      addr_bus    <= '0;
      mem_bus_out <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      state_q     <= state_nx;
      src_q       <= src_nx;
      dst_q       <= dst_nx;
      rem_q       <= rem_nx;
      tmo_q       <= tmo_nx;
      abort_q     <= abort_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      error       <= error_nx;
      words_done  <= words_nx;
      addr_bus    <= addr_nx;
      mem_bus_out <= wdata_nx;
      mem_read    <= rd_nx;
      mem_write   <= wr_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    src_nx   = src_q;
    dst_nx   = dst_q;
    rem_nx   = rem_q;
    tmo_nx   = tmo_q;
    abort_nx = abort_q | (busy & abort);
    busy_nx  = busy;
    done_nx  = 1'b0;
    error_nx = error;
    words_nx = words_done;
    addr_nx  = addr_bus;
    wdata_nx = mem_bus_out;
    rd_nx    = mem_read;
    wr_nx    = mem_write;

    case (state_q)
      IDLE: begin
        if (start) begin
          error_nx = 1'b0;
          words_nx = '0;
          abort_nx = 1'b0;
          if (length != 16'd0) begin
            src_nx   = src_addr;
            dst_nx   = dst_addr;
            rem_nx   = length;
            tmo_nx   = '0;
            busy_nx  = 1'b1;
            rd_nx    = 1'b1;
            addr_nx  = src_addr;
            state_nx = RD;
          end else begin
            done_nx = 1'b1;
          end
        end
      end

      RD: begin
        if (mem_ack) begin
          wdata_nx = mem_bus_in;
          rd_nx    = 1'b0;
          wr_nx    = 1'b1;
          addr_nx  = dst_q;
          tmo_nx   = '0;
          state_nx = WR;
        end
      end

      WR: begin
        if (mem_ack) begin
          wr_nx    = 1'b0;
          words_nx = words_done + 16'd1;
          src_nx   = src_q + 16'd1;
          dst_nx   = dst_q + 16'd1;
          rem_nx   = rem_q - 16'd1;
          tmo_nx   = '0;
          // A pending abort (sticky or arriving now) ends the copy once this word is written.
          if (rem_q == 16'd1 || abort_q || abort) begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            abort_nx = 1'b0;
            state_nx = IDLE;
          end else begin
            rd_nx    = 1'b1;
            addr_nx  = src_q + 16'd1;
            state_nx = RD;
          end
        end
      end

      default: state_nx = IDLE;
    endcase

    // Unanswered request: count the wait and give up after TIMEOUT cycles high.
    if (state_q != IDLE && !mem_ack) begin
      if (tmo_q == TMO_LAST) begin
        rd_nx    = 1'b0;
        wr_nx    = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
        error_nx = 1'b1;
        abort_nx = 1'b0;
        tmo_nx   = '0;
        state_nx = IDLE;
      end else begin
        tmo_nx = tmo_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sextium_dma_master.sv
// Self-checking bench for sextium_dma_master: 1-cycle-ack RAM responder plus a
// scoreboard of expected bus reads/writes, with timing, timeout, abort and reset checks.
module tb_sextium_dma_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr, dst_addr, length;
  logic        abort;
  logic        busy, done, error;
  logic [15:0] words_done, addr_bus, mem_bus_in, mem_bus_out;
  logic        mem_read, mem_write, mem_ack;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];
  logic [15:0] rd_e;
  wr_t         wr_e;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] mem [0:65535];
  logic        resp_en, resp_ack, force_ack, pl_en;
  logic [15:0] pl_addr, pl_data;
  logic        prev_rd_ack = 1'b0;
  logic        prev_wr_ack = 1'b0;

  int done_cyc, busy_cnt, rd_cnt;

  sextium_dma_master #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .abort(abort),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .addr_bus(addr_bus), .mem_bus_in(mem_bus_in), .mem_bus_out(mem_bus_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  assign mem_ack = resp_ack | force_ack;

  // RAM responder: acks one cycle after a request appears, never twice in a row.
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write && mem_ack) mem[addr_bus] <= mem_bus_out;
    if (mem_read && !resp_ack) mem_bus_in <= mem[addr_bus];
    if (reset || !resp_en) resp_ack <= 1'b0;
    else resp_ack <= (mem_read | mem_write) & ~resp_ack;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Bus monitor: handshake rules and scoreboard pops on completed transfers.
  always @(negedge clock) begin
    checkOutput("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
    checkOutput("read_held", 32'(prev_rd_ack & mem_read), 32'd0);
    checkOutput("write_held", 32'(prev_wr_ack & mem_write), 32'd0);
    if (mem_read && mem_ack) begin
      if (exp_rd.size() == 0) checkOutput("rd_unexpected", 32'(addr_bus), 32'hFFFF_FFFF);
      else begin
        rd_e = exp_rd.pop_front();
        checkOutput("rd_addr", 32'(addr_bus), 32'(rd_e));
      end
    end
    if (mem_write && mem_ack) begin
      if (exp_wr.size() == 0) checkOutput("wr_unexpected", 32'(addr_bus), 32'hFFFF_FFFF);
      else begin
        wr_e = exp_wr.pop_front();
        checkOutput("wr_addr", 32'(addr_bus), 32'(wr_e.addr));
        checkOutput("wr_data", 32'(mem_bus_out), 32'(wr_e.data));
      end
    end
    prev_rd_ack = mem_read & mem_ack;
    prev_wr_ack = mem_write & mem_ack;
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  // Pulses start for one cycle and queues the bus traffic expected to complete.
  task automatic applyStimulus(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                               input int n_rd, input int n_wr);
    wr_t w;
    for (int i = 0; i < n_rd; i++) exp_rd.push_back(16'(src + 16'(i)));
    for (int i = 0; i < n_wr; i++) begin
      w.addr = 16'(dst + 16'(i));
      w.data = mem[16'(src + 16'(i))];
      exp_wr.push_back(w);
    end
    start = 1'b1;
    src_addr = src;
    dst_addr = dst;
    length = len;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic runTransfer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                             input int n_rd, input int n_wr, input int abort_at, input int extra_start_at,
                             output int d_cyc, output int b_cnt, output int r_cnt);
    applyStimulus(src, dst, len, n_rd, n_wr);
    d_cyc = -1;
    b_cnt = 0;
    r_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      if (busy) b_cnt++;
      if (mem_read) r_cnt++;
      if (done) begin
        d_cyc = k;
        break;
      end
      abort = (k == abort_at);
      start = (k == extra_start_at);
      if (start) begin
        src_addr = 16'h0500;
        dst_addr = 16'h0600;
        length = 16'd5;
      end
      @(posedge clock); #1;
    end
    abort = 1'b0;
    start = 1'b0;
    if (d_cyc < 0) checkOutput("done_bound", 32'd0, 32'd1);
    checkOutput("rd_left", 32'(exp_rd.size()), 32'd0);
    checkOutput("wr_left", 32'(exp_wr.size()), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    resp_en = 1'b1;
    force_ack = 1'b0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    repeat (2) @(posedge clock);
    #1;
    preload(16'h0010, 16'hAAAA);
    preload(16'h0011, 16'hBBBB);
    preload(16'h0012, 16'hCCCC);
    preload(16'hFFFF, 16'h1234);
    preload(16'h0000, 16'h5678);
    preload(16'h0040, 16'h4000);
    preload(16'h0041, 16'h4001);
    preload(16'h0042, 16'h4002);

    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_words", 32'(words_done), 32'd0);
    checkOutput("rst_read", 32'(mem_read), 32'd0);
    checkOutput("rst_write", 32'(mem_write), 32'd0);
    checkOutput("rst_addr", 32'(addr_bus), 32'd0);
    checkOutput("rst_wdata", 32'(mem_bus_out), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Normal 3-word copy
    runTransfer(16'h0010, 16'h0100, 16'd3, 3, 3, 0, 0, done_cyc, busy_cnt, rd_cnt);
    checkOutput("t1_done_cyc", 32'(done_cyc), 32'd13);
    checkOutput("t1_busy_cycles", 32'(busy_cnt), 32'd12);
    checkOutput("t1_words", 32'(words_done), 32'd3);
    checkOutput("t1_error", 32'(error), 32'd0);
    checkOutput("t1_mem0", 32'(mem[16'h0100]), 32'hAAAA);
    checkOutput("t1_mem1", 32'(mem[16'h0101]), 32'hBBBB);
    checkOutput("t1_mem2", 32'(mem[16'h0102]), 32'hCCCC);
    @(posedge clock); #1;
    checkOutput("t1_done_pulse", 32'(done), 32'd0);

    // Address wrap-around
    runTransfer(16'hFFFF, 16'h7FFF, 16'd2, 2, 2, 0, 0, done_cyc, busy_cnt, rd_cnt);
    checkOutput("t2_done_cyc", 32'(done_cyc), 32'd9);
    checkOutput("t2_words", 32'(words_done), 32'd2);
    checkOutput("t2_mem0", 32'(mem[16'h7FFF]), 32'h1234);
    checkOutput("t2_mem1", 32'(mem[16'h8000]), 32'h5678);
    @(posedge clock); #1;

    // Zero-length command
    applyStimulus(16'h0010, 16'h0200, 16'd0, 0, 0);
    checkOutput("t3_done", 32'(done), 32'd1);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    checkOutput("t3_read", 32'(mem_read), 32'd0);
    checkOutput("t3_write", 32'(mem_write), 32'd0);
    checkOutput("t3_words", 32'(words_done), 32'd0);
    @(posedge clock); #1;
    checkOutput("t3_done_drop", 32'(done), 32'd0);
    checkOutput("t3_busy2", 32'(busy), 32'd0);

    // Ack timeout with a silent responder
    resp_en = 1'b0;
    runTransfer(16'h0020, 16'h0200, 16'd2, 0, 0, 0, 0, done_cyc, busy_cnt, rd_cnt);
    checkOutput("t4_read_cycles", 32'(rd_cnt), 32'd16);
    checkOutput("t4_done_cyc", 32'(done_cyc), 32'd17);
    checkOutput("t4_error", 32'(error), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_read_drop", 32'(mem_read), 32'd0);
    checkOutput("t4_words", 32'(words_done), 32'd0);
    @(posedge clock); #1;
    checkOutput("t4_error_held", 32'(error), 32'd1);
    checkOutput("t4_done_drop", 32'(done), 32'd0);
    resp_en = 1'b1;
    applyStimulus(16'h0010, 16'h0110, 16'd1, 1, 1);
    checkOutput("t4_error_clear", 32'(error), 32'd0);
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clock); #1;
    end
    checkOutput("t4_restart_done", 32'(done), 32'd1);
    checkOutput("t4_restart_words", 32'(words_done), 32'd1);
    checkOutput("t4_restart_wr_left", 32'(exp_wr.size()), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    @(posedge clock); #1;

    // Abort during word 2's read
    runTransfer(16'h0040, 16'h0400, 16'd10, 3, 3, 9, 0, done_cyc, busy_cnt, rd_cnt);
    checkOutput("t5_done_cyc", 32'(done_cyc), 32'd13);
    checkOutput("t5_words", 32'(words_done), 32'd3);
    checkOutput("t5_error", 32'(error), 32'd0);
    @(posedge clock); #1;

    // Start while busy is ignored
    runTransfer(16'h0010, 16'h0140, 16'd2, 2, 2, 0, 5, done_cyc, busy_cnt, rd_cnt);
    checkOutput("t6_done_cyc", 32'(done_cyc), 32'd9);
    checkOutput("t6_words", 32'(words_done), 32'd2);
    @(posedge clock); #1;

    // Idle ack pulse is ignored
    force_ack = 1'b1;
    @(posedge clock); #1;
    force_ack = 1'b0;
    checkOutput("t6_idle_busy", 32'(busy), 32'd0);
    checkOutput("t6_idle_read", 32'(mem_read), 32'd0);
    checkOutput("t6_idle_write", 32'(mem_write), 32'd0);
    checkOutput("t6_idle_done", 32'(done), 32'd0);

    // Reset while a write is pending
    applyStimulus(16'h0010, 16'h0300, 16'd2, 1, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("t6_write_pending", 32'(mem_write), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_write", 32'(mem_write), 32'd0);
    checkOutput("t6_rst_read", 32'(mem_read), 32'd0);
    checkOutput("t6_rst_addr", 32'(addr_bus), 32'd0);
    checkOutput("t6_rst_wdata", 32'(mem_bus_out), 32'd0);
    checkOutput("t6_rst_words", 32'(words_done), 32'd0);
    checkOutput("t6_rst_done", 32'(done), 32'd0);
    checkOutput("t6_rst_rd_left", 32'(exp_rd.size()), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    @(posedge clock); #1;
    runTransfer(16'h0011, 16'h0310, 16'd1, 1, 1, 0, 0, done_cyc, busy_cnt, rd_cnt);
    checkOutput("t6_after_done_cyc", 32'(done_cyc), 32'd5);
    checkOutput("t6_after_words", 32'(words_done), 32'd1);
    checkOutput("t6_after_mem", 32'(mem[16'h0310]), 32'hBBBB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
